signal_merger: RTL and testbench
================================

// Module: signal_merger
// PURPOSE
//  Reverse of the 4-way router: merges four 16-bit input channels onto one output.
//  Round-robin arbitration with valid/ready handshakes.
//  Each output word carries a 3-bit source tag in the same encoding as the router's dest_addr.
//  Sits upstream of the router so traffic from four producers can share one routed path.
// PARAMETERS
//  DATA_W  16  width of every data channel
//  TAG_W   3   width of src_addr; matches router dest_addr
//  CNT_W   16  width of the per-channel grant counters (stats option only)
// PORTS
//  clk        in   1      rising-edge clock
//  rst        in   1      asynchronous, active-low reset
//  data_in_0  in   DATA_W channel 0 data; data_in_1..data_in_3 identical for ch 1..3
//  in_valid   in   4      bit i: channel i presents a word
//  in_ready   out  4      bit i: channel i word accepted this cycle (combinational)
//  data_out   out  DATA_W merged data
//  src_addr   out  TAG_W  channel index (0..3) of data_out
//  out_valid  out  1      data_out/src_addr valid
//  out_ready  in   1      downstream accepts the word
//  cnt_sel    in   2      selects the channel whose grant count appears on cnt_out
//  cnt_out    out  CNT_W  grant count of channel cnt_sel
// BEHAVIOUR
//  Reset (rst low, async): out_valid=0, data_out=0, src_addr=0, last_grant=3, counters=0.
//   - After reset, channel 0 has top priority.
//  Output stage FSM, 2 states:
//   - EMPTY: out_valid=0.
//   - FULL: out_valid=1.
//   - EMPTY -> FULL when any in_valid bit is set.
//   - FULL -> EMPTY when out_ready=1 and no in_valid bit is set.
//   - FULL -> FULL when out_ready=1 and some in_valid bit is set (back-to-back load).
//   - FULL -> FULL (hold) when out_ready=0.
//  load_en = !out_valid || out_ready.
//   - At most one in_ready bit is high: in_ready[g]=load_en && in_valid[g].
//   - g = first requesting channel scanning last_grant+1, +2, +3, +4 (mod 4).
//  On transfer: data_out<=data_in_g; src_addr<={0,g[1:0]}; last_grant<=g; out_valid<=1.
//  Latency: word accepted at edge N appears on data_out after edge N, i.e. 1 cycle.
//  Throughput: one word per clock while out_ready=1.
//  Stall (out_valid=1, out_ready=0): data_out, src_addr, last_grant stable; in_ready=0.
//  Clearing: when out_valid=1 and out_ready=1 with no requester, out_valid<=0.
//   - data_out and src_addr keep their last value.
//  in_valid bits low: that channel never receives in_ready.
//   - An idle channel is skipped with no bubble.
//  Single requester: granted every cycle, irrespective of last_grant.
//  Fairness: with all four requesting continuously, grants run 0,1,2,3,0,...
//   - Each channel waits at most 3 grants.
//  src_addr bit 2 is always 0; values 4..7 are never produced.
//  Reset mid-transfer: word in output stage is discarded.
//   - Output stage returns to EMPTY immediately; no partial state survives.
// CONFIGURATION
//  MERGER_STATS_EN defined:
//   - Four CNT_W counters, each +1 per transfer from its channel.
//   - Counters saturate at all-ones; no wrap.
//   - cnt_out = counter[cnt_sel], combinational.
//  MERGER_STATS_EN undefined:
//   - No counters; cnt_out tied to 0.
//   - cnt_sel ignored; port list unchanged.
// TESTING
//  T1 reset: rst low mid-stream -> out_valid=0, data_out=0, src_addr=0 same cycle.
//     After release, all 4 valid -> first grant ch0.
//  T2 single: only ch2 valid, data 16'hA5A5, out_ready=1 -> next cycle data_out=16'hA5A5, src_addr=2.
//     Sustained: in_ready[2]=1 every cycle.
//  T3 round-robin: all four valid, data_in_i=16'h1000+i, out_ready=1 for 8 cycles
//     -> src_addr 0,1,2,3,0,1,2,3.
//  T4 stall: out_valid=1, out_ready=0 for 5 cycles -> data_out/src_addr constant, in_ready=4'b0000.
//     Release -> next channel in order granted.
//  T5 skip: only ch1,ch3 valid -> grants alternate 1,3,1,3 with no idle cycles.
//     Then all in_valid drop -> out_valid falls after the last accepted word.
//  T6 stats (MERGER_STATS_EN): 10 transfers from ch3, cnt_sel=3 -> cnt_out=10.
//     Force counter to all-ones -> stays all-ones; without macro cnt_out=0.

Source files
------------

// File: rtl/signal_merger.sv
// Four-channel round-robin merger: one registered output word per clock, tagged with its source channel.
// Optional per-channel grant counters are enabled by defining MERGER_STATS_EN.
module signal_merger #(
  parameter int DATA_W = 16,
  parameter int TAG_W  = 3,
  parameter int CNT_W  = 16
) (
  input  logic              clk,
  input  logic              rst,
  input  logic [DATA_W-1:0] data_in_0,
  input  logic [DATA_W-1:0] data_in_1,
  input  logic [DATA_W-1:0] data_in_2,
  input  logic [DATA_W-1:0] data_in_3,
  input  logic [3:0]        in_valid,
  output logic [3:0]        in_ready,
  output logic [DATA_W-1:0] data_out,
  output logic [TAG_W-1:0]  src_addr,
  output logic              out_valid,
  input  logic              out_ready,
  input  logic [1:0]        cnt_sel,
  output logic [CNT_W-1:0]  cnt_out
);

  typedef enum logic {EMPTY, FULL} state_t;

  state_t            state_q, state_d;
  logic [1:0]        last_grant_q;
  logic [DATA_W-1:0] data_q;
  logic [TAG_W-1:0]  src_q;

  logic [DATA_W-1:0] data_in_arr [4];
  logic [1:0]        grant;
  logic              any_req;
  logic              load_en;
  logic              xfer;

  assign data_in_arr[0] = data_in_0;
  assign data_in_arr[1] = data_in_1;
  assign data_in_arr[2] = data_in_2;
  assign data_in_arr[3] = data_in_3;

  assign any_req   = |in_valid;
  assign out_valid = (state_q == FULL);
  assign load_en   = !out_valid || out_ready;
  assign xfer      = load_en && any_req;
  assign data_out  = data_q;
  assign src_addr  = src_q;

  // Scan starts just after the previous winner; the fourth step wraps back to it.
  always_comb begin
    logic [1:0] cand;
    logic       found;
    grant = last_grant_q;
    found = 1'b0;
    cand  = last_grant_q;
    for (int k = 1; k <= 4; k++) begin
      cand = last_grant_q + 2'(k);
      if (!found && in_valid[cand]) begin
        grant = cand;
        found = 1'b1;
      end
    end
  end

  always_comb begin
    in_ready = '0;
    if (xfer) begin
      in_ready[grant] = 1'b1;
    end
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      EMPTY:   if (any_req) state_d = FULL;
      FULL:    if (out_ready && !any_req) state_d = EMPTY;
      default: state_d = EMPTY;
    endcase
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q      <= EMPTY;
      last_grant_q <= 2'd3;
      data_q       <= '0;
      src_q        <= '0;
    end else begin
      state_q <= state_d;
      if (xfer) begin
        last_grant_q <= grant;
        data_q       <= data_in_arr[grant];
        src_q        <= {{(TAG_W-2){1'b0}}, grant};
      end
    end
  end

`ifdef MERGER_STATS_EN
  logic [CNT_W-1:0] cnt_arr [4];

  for (genvar gi = 0; gi < 4; gi++) begin : g_cnt
    logic [CNT_W-1:0] cnt_q;

    // Saturating: a stuck-at-max counter is more useful than one that wraps to a small value.
    always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
        cnt_q <= '0;
      end else if (in_ready[gi] && (cnt_q != {CNT_W{1'b1}})) begin
        cnt_q <= cnt_q + 1'b1;
      end
    end

    assign cnt_arr[gi] = cnt_q;
  end

  assign cnt_out = cnt_arr[cnt_sel];
`else
  logic unused_cnt_sel;

  assign unused_cnt_sel = ^cnt_sel;
  assign cnt_out        = '0;
`endif

endmodule

// File: tb/tb_signal_merger.sv
// Randomised scoreboard bench for signal_merger; an abstract round-robin model predicts every accepted word.
// Directed phases cover reset, single requester, rotation, stall, skip/drain and the MERGER_STATS_EN counters.
module tb_signal_merger;

  logic        clk = 1'b0;
  logic        rst;
  logic [15:0] din [4];
  logic [3:0]  in_valid;
  logic [3:0]  in_ready;
  logic [15:0] data_out;
  logic [2:0]  src_addr;
  logic        out_valid;
  logic        out_ready;
  logic [1:0]  cnt_sel;
  logic [15:0] cnt_out;

  signal_merger #(.DATA_W(16), .TAG_W(3), .CNT_W(16)) dut (
    .clk       (clk),
    .rst       (rst),
    .data_in_0 (din[0]),
    .data_in_1 (din[1]),
    .data_in_2 (din[2]),
    .data_in_3 (din[3]),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .data_out  (data_out),
    .src_addr  (src_addr),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .cnt_sel   (cnt_sel),
    .cnt_out   (cnt_out)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [15:0] d;
    logic [2:0]  t;
  } exp_t;

  exp_t        sb_q [$];
  int          n_checks = 0;
  int          n_fail   = 0;
  bit          quiet    = 1'b0;

  // Reference model: what the output stage should hold and who won last.
  int          m_last;
  bit          m_valid;
  logic [15:0] m_data;
  int          m_tag;
  int unsigned m_cnt [4];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic model_reset();
    sb_q.delete();
    m_last  = 3;
    m_valid = 1'b0;
    m_data  = '0;
    m_tag   = 0;
    for (int i = 0; i < 4; i++) m_cnt[i] = 0;
  endtask

  // Entered just after a rising edge; leaves just after the next one.
  task automatic do_reset();
    rst = 1'b0;
    #1;
    chk("rst_out_valid", out_valid, 0);
    chk("rst_data_out", data_out, 0);
    chk("rst_src_addr", src_addr, 0);
    chk("rst_cnt_out", cnt_out, 0);
    model_reset();
    in_valid  = '0;
    out_ready = 1'b0;
    @(posedge clk);
    #1;
    rst = 1'b1;
  endtask

  task automatic step(input logic [3:0] v, input bit ordy, input logic [1:0] sel);
    int g;
    int c;
    logic [3:0] exp_rdy;
    chk("out_valid", out_valid, m_valid);
    if (m_valid) begin
      chk("held_data", data_out, m_data);
      chk("held_tag", src_addr, m_tag);
    end
    in_valid  = v;
    out_ready = ordy;
    cnt_sel   = sel;
    #1;
    g = -1;
    if (!m_valid || ordy) begin
      for (int k = 1; k <= 4; k++) begin
        c = (m_last + k) % 4;
        if (g < 0 && v[c]) g = c;
      end
    end
    exp_rdy = (g >= 0) ? (4'b0001 << g) : 4'b0000;
    chk("in_ready", in_ready, exp_rdy);
`ifdef MERGER_STATS_EN
    chk("cnt_out", cnt_out, m_cnt[sel]);
`else
    chk("cnt_out_tied", cnt_out, 0);
`endif
    if (g >= 0) begin
      sb_q.push_back('{din[g], 3'(g)});
      m_data  = din[g];
      m_tag   = g;
      m_valid = 1'b1;
      m_last  = g;
      if (m_cnt[g] < 32'd65535) m_cnt[g]++;
    end else if (ordy) begin
      m_valid = 1'b0;
    end
    @(posedge clk);
    #1;
  endtask

  // Scoreboard monitor: a word leaves the DUT whenever out_valid and out_ready meet.
  always @(negedge clk) begin
    exp_t e;
    if (rst && out_valid && out_ready) begin
      n_checks++;
      if (sb_q.size() == 0) begin
        n_fail++;
        $display("FAIL sb_unexpected: got data %h tag %0d expected no word", data_out, src_addr);
      end else begin
        e = sb_q.pop_front();
        if (data_out !== e.d || src_addr !== e.t) begin
          n_fail++;
          $display("FAIL sb_word: got data %h tag %0d expected data %h tag %0d",
                   data_out, src_addr, e.d, e.t);
        end else if (!quiet) begin
          $display("xfer ch%0d data %h", src_addr, data_out);
        end
      end
    end
  end

  initial begin
    rst       = 1'b0;
    in_valid  = '0;
    out_ready = 1'b0;
    cnt_sel   = '0;
    for (int i = 0; i < 4; i++) din[i] = 16'h1000 + 16'(i);
    @(posedge clk);
    #1;
    do_reset();

    // T1: first grant after reset goes to ch0, then reset lands mid-stream.
    step(4'hF, 1'b1, 2'd0);
    chk("t1_first_grant", src_addr, 0);
    step(4'hF, 1'b1, 2'd1);
    step(4'hF, 1'b1, 2'd2);
    do_reset();

    // T2: lone requester on ch2 is granted every cycle.
    din[2] = 16'hA5A5;
    for (int k = 0; k < 5; k++) begin
      din[0] = 16'($urandom);
      step(4'b0100, 1'b1, 2'd2);
      chk("t2_data", data_out, 16'hA5A5);
      chk("t2_tag", src_addr, 2);
    end
    do_reset();

    // T3: all four requesting rotate 0,1,2,3,...
    for (int i = 0; i < 4; i++) din[i] = 16'h1000 + 16'(i);
    for (int k = 0; k < 8; k++) begin
      step(4'hF, 1'b1, 2'(k));
      chk("t3_rotation", src_addr, k % 4);
    end

    // T4: stall holds the word and blocks all inputs; release resumes with ch0.
    for (int k = 0; k < 5; k++) step(4'hF, 1'b0, 2'd3);
    step(4'hF, 1'b1, 2'd0);
    chk("t4_resume", src_addr, 0);

    // T5: ch1/ch3 alternate without bubbles, then the stage drains.
    for (int k = 0; k < 6; k++) begin
      for (int i = 0; i < 4; i++) din[i] = 16'($urandom);
      step(4'b1010, 1'b1, 2'd1);
      chk("t5_skip", src_addr, (k % 2 == 0) ? 1 : 3);
    end
    step(4'b0000, 1'b1, 2'd0);
    chk("t5_drain", out_valid, 0);

    // Randomised traffic with random back-pressure.
    for (int k = 0; k < 400; k++) begin
      for (int i = 0; i < 4; i++) din[i] = 16'($urandom);
      step(4'($urandom), ($urandom % 4) != 0, 2'($urandom));
    end
    step(4'b0000, 1'b1, 2'd0);
    step(4'b0000, 1'b1, 2'd0);
    chk("sb_empty", sb_q.size(), 0);

`ifdef MERGER_STATS_EN
    // T6: ten ch3 transfers, then saturate ch0.
    do_reset();
    for (int k = 0; k < 10; k++) step(4'b1000, 1'b1, 2'd3);
    step(4'b0000, 1'b1, 2'd3);
    chk("t6_count10", cnt_out, 10);
    quiet = 1'b1;
    for (int k = 0; k < 65540; k++) step(4'b0001, 1'b1, 2'd0);
    quiet = 1'b0;
    step(4'b0000, 1'b1, 2'd0);
    chk("t6_saturate", cnt_out, 16'hFFFF);
`else
    for (int s = 0; s < 4; s++) begin
      cnt_sel = 2'(s);
      #1;
      chk("t6_no_stats", cnt_out, 0);
    end
`endif

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
